// File: rtl/layer_mem_arb.sv
// Two-port round-robin arbiter onto one layer memory; ties go to port 0 when LAYER_MEM_ARB_FIXED_PRIO_EN is defined.
// Grant and memory command 1 cycle after request, read return 3 cycles after request; a port waits (req held) until its gnt.
module layer_mem_arb #(
  parameter int AW = 12,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_wr,
  input  logic [2:0]    r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic          r1_wr,
  input  logic [2:0]    r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic [DW-1:0] r1_rdata,
  output logic          cwr,
  output logic          crd,
  output logic [2:0]    csel,
  output logic [AW-1:0] caddr_wr,
  output logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_wr,
  input  logic [DW-1:0] cdata_rd,
  output logic          arb_idle
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_e0;
  logic          w_e1;
  logic          w_tie_p0;
  logic          w_win1;
  logic          w_wr;
  logic [2:0]    w_sel;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          r_tag1_vld;
  logic          r_tag1_own;
  logic          r_tag2_vld;
  logic          r_tag2_own;

  assign r0_gnt = (r_state == G0);
  assign r1_gnt = (r_state == G1);

  // A port granted this cycle sits out the next arbitration round.
  assign w_e0 = r0_req & ~r0_gnt;
  assign w_e1 = r1_req & ~r1_gnt;

`ifdef LAYER_MEM_ARB_FIXED_PRIO_EN
  assign w_tie_p0 = 1'b1;
`else
  logic r_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (w_next == G0) begin
      r_last <= 1'b0;
    end else if (w_next == G1) begin
      r_last <= 1'b1;
    end
  end

  assign w_tie_p0 = r_last;
`endif

  always_comb begin
    w_next = IDLE;
    if (w_e0 && w_e1) begin
      w_next = w_tie_p0 ? G0 : G1;
    end else if (w_e0) begin
      w_next = G0;
    end else if (w_e1) begin
      w_next = G1;
    end
  end

  assign w_win1  = (w_next == G1);
  assign w_wr    = w_win1 ? r1_wr    : r0_wr;
  assign w_sel   = w_win1 ? r1_sel   : r0_sel;
  assign w_addr  = w_win1 ? r1_addr  : r0_addr;
  assign w_wdata = w_win1 ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      cwr        <= 1'b0;
      crd        <= 1'b0;
      csel       <= '0;
      caddr_wr   <= '0;
      caddr_rd   <= '0;
      cdata_wr   <= '0;
      r_tag1_vld <= 1'b0;
      r_tag1_own <= 1'b0;
      r_tag2_vld <= 1'b0;
      r_tag2_own <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      r_state <= w_next;
      cwr     <= 1'b0;
      crd     <= 1'b0;
      if (w_next != IDLE) begin
        csel <= w_sel;
        if (w_wr) begin
          cwr      <= 1'b1;
          caddr_wr <= w_addr;
          cdata_wr <= w_wdata;
        end else begin
          crd      <= 1'b1;
          caddr_rd <= w_addr;
        end
      end
      // Stage 1 aligns with crd, stage 2 with cdata_rd returning from memory.
      r_tag1_vld <= (w_next != IDLE) & ~w_wr;
      r_tag1_own <= w_win1;
      r_tag2_vld <= r_tag1_vld;
      r_tag2_own <= r_tag1_own;
      r0_rvalid  <= r_tag2_vld & ~r_tag2_own;
      r1_rvalid  <= r_tag2_vld & r_tag2_own;
      if (r_tag2_vld && !r_tag2_own) begin
        r0_rdata <= cdata_rd;
      end
      if (r_tag2_vld && r_tag2_own) begin
        r1_rdata <= cdata_rd;
      end
    end
  end

  assign arb_idle = ~reset | (~r0_req & ~r1_req & (r_state == IDLE) &
                              ~r_tag1_vld & ~r_tag2_vld & ~r0_rvalid & ~r1_rvalid);

endmodule

// File: doc/layer_mem_arb.md
LAYER_MEM_ARB -- requirements
Module: layer_mem_arb

Interface
REQ-001 Parameter AW, default 12, memory address width (64x64 map).
REQ-002 Parameter DW, default 20, memory data width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 r0_req, r1_req  in  1 each  port request; requester SHALL hold it with the command fields until its gnt.
REQ-007 r0_wr, r1_wr  in  1 each  1 = write, 0 = read.
REQ-008 r0_sel, r1_sel  in  3 each  layer memory select.
REQ-009 r0_addr, r1_addr  in  AW each  memory address.
REQ-010 r0_wdata, r1_wdata  in  DW each  write data.
REQ-011 r0_gnt, r1_gnt  out  1 each  one-cycle pulse: command accepted and driven to memory this cycle.
REQ-012 r0_rvalid, r1_rvalid  out  1 each  one-cycle read-return pulse.
REQ-013 r0_rdata, r1_rdata  out  DW each  read data, valid with own rvalid, held otherwise.
REQ-014 cwr / crd  out  1 each  memory write / read strobe.
REQ-015 csel  out  3  memory select; caddr_wr, caddr_rd  out  AW each  write/read address.
REQ-016 cdata_wr  out  DW  write data; cdata_rd  in  DW  read data, valid the cycle after crd.
REQ-017 arb_idle  out  1  high when no request pending, no grant, no read in flight.

Function
REQ-018 Grant FSM SHALL have states IDLE, G0, G1, meaning no port, port 0 or port 1 granted in the current cycle.
REQ-019 Port N SHALL be eligible in cycle C iff rN_req=1 and rN_gnt=0 in C (granted port masked for one cycle).
REQ-020 Next state: neither eligible -> IDLE; one eligible -> its Gn; both -> port not equal to last_grant (round-robin).
REQ-021 Requests sampled in cycle C SHALL produce gnt and registered memory outputs in cycle C+1.
REQ-022 Granted write: cwr=1, csel, caddr_wr and cdata_wr from winner; granted read: crd=1, csel, caddr_rd from winner.
REQ-023 Cycles with no grant: cwr=crd=0; csel, addresses and cdata_wr SHALL hold prior values.
REQ-024 A read issued in C+1 SHALL register cdata_rd in C+2 and pulse the owner's rvalid with rdata in C+3.
REQ-025 Read owner SHALL be tracked through a 2-stage tag pipeline; returns in issue order, never routed to the other port.
REQ-026 Throughput: at most one command per cycle total, at most one per two cycles per port.
REQ-027 req withdrawn before gnt: no command issued, no state change beyond arbitration.
REQ-028 Field values (sel, addr, data) SHALL be passed unchecked; sel=0 is legal.

Reset
REQ-029 While reset=0: all outputs 0, arb_idle=1, state IDLE, last_grant=1 (port 0 wins first tie), read tags cleared.
REQ-030 Reset mid-transaction SHALL discard in-flight reads; no rvalid after release.
REQ-031 First grant SHALL occur no earlier than the cycle after the first rising edge with reset=1.

Configuration
REQ-032 Macro LAYER_MEM_ARB_FIXED_PRIO_EN defined: ties SHALL always go to port 0; last_grant unused; REQ-019 masking still applies.
REQ-033 Macro undefined: round-robin per REQ-020.

Verification
REQ-034 r0 write sel=1 addr=0x041 wdata=0x00ABC, req in cycle 0 -> cycle 1: r0_gnt=1, cwr=1, csel=1, caddr_wr=0x041, cdata_wr=0x00ABC; cycle 2: cwr=0.
REQ-035 r1 read sel=3 addr=0x010, memory returns 0x12345 -> cycle 1: r1_gnt, crd=1, caddr_rd=0x010; cycle 3: r1_rvalid=1, r1_rdata=0x12345; r0_rvalid stays 0.
REQ-036 r0 read 0x001 (mem 0x00011) and r1 read 0x002 (mem 0x00022), both req cycle 0 -> r0_gnt cycle 1, r1_gnt cycle 2, r0_rvalid/0x00011 cycle 3, r1_rvalid/0x00022 cycle 4.
REQ-037 r0 write granted cycle 1, both reqs high cycle 2 -> round-robin: r1_gnt cycle 3; with LAYER_MEM_ARB_FIXED_PRIO_EN: r0_gnt cycle 3.
REQ-038 Both ports held requesting cycles 0-5 -> grants alternate r0, r1, r0, r1, ... from cycle 1, never both in one cycle.
REQ-039 Read granted cycle 1, reset=0 during cycle 2 -> outputs 0 immediately; after release no rvalid, arb_idle=1.
